neuron_integrator: RTL and testbench
====================================

NEURON_INTEGRATOR -- requirements
Module: neuron_integrator

Interface
REQ-001 SHALL have parameter NUM_AXONS, default 256, meaning maximum axon events per integration.
REQ-002 SHALL have parameter ACC_W, default 17, meaning signed accumulator width.
REQ-003 SHALL have port wb_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  in  1  one-cycle pulse to begin one neuron update.
REQ-006 SHALL have ports axon_valid_i  in  1, axon_spike_i  in  1, axon_type_i  in  2, axon_last_i  in  1; one axon event per accepted beat, with axon_type_i selecting weight 1..4 as 0..3.
REQ-007 SHALL have port axon_ready_o  out  1  ready for an axon event.
REQ-008 SHALL have signed 8-bit inputs voltage_potential_i, pos_threshold_i, neg_threshold_i, leak_value_i, weight_type1_i..weight_type4_i, pos_reset_i, neg_reset_i (parameter-store outputs).
REQ-009 SHALL have port vp_o  out  8  signed new voltage potential for the parameter store.
REQ-010 SHALL have port vp_we_o  out  1  one-cycle write strobe paired with vp_o.
REQ-011 SHALL have ports spike_o  out  1 (one-cycle fire pulse), busy_o  out  1, done_o  out  1 (one-cycle completion pulse).

Function
REQ-012 SHALL implement FSM states IDLE, INTEG, LEAK, FIRE, WB.
REQ-013 IDLE->INTEG on start_i; accumulator loads sign-extended voltage_potential_i and the axon counter clears in that same edge.
REQ-014 INTEG SHALL drive axon_ready_o=1; a beat is accepted when axon_valid_i && axon_ready_o.
REQ-015 On an accepted beat with axon_spike_i=1, the accumulator SHALL add the sign-extended weight selected by axon_type_i; with axon_spike_i=0, it SHALL remain unchanged. The axon counter SHALL increment on every accepted beat.
REQ-016 INTEG->LEAK when the accepted beat has axon_last_i=1 or the counter reaches NUM_AXONS-1, whichever occurs first; further beats SHALL not be accepted.
REQ-017 LEAK SHALL add sign-extended leak_value_i, taking one cycle, then go to FIRE.
REQ-018 FIRE SHALL compute next_vp:
- acc >= pos_threshold_i: spike_o=1 for this cycle, next_vp=pos_reset_i.
- else if acc < neg_threshold_i: next_vp=neg_reset_i, no spike.
- else next_vp=acc saturated to [-128,127].
REQ-019 WB SHALL assert vp_we_o=1 with vp_o=next_vp and done_o=1 for exactly one cycle, then go to IDLE.
REQ-020 Latency from the accepted last beat to vp_we_o SHALL be 3 cycles (LEAK, FIRE, WB).
REQ-021 Accumulator width SHALL be 17 bits, with no intermediate wrap (the worst case of 256 x -128 + -128 + -128 is within range).
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 Parameter inputs SHALL be sampled live; they are required stable from start_i to done_o.

Reset
REQ-025 Assertion of wb_rst_ni, including mid-operation, SHALL force IDLE, clear the accumulator and counter, and zero axon_ready_o, vp_o, vp_we_o, spike_o, busy_o and done_o; no write strobe SHALL be issued for the aborted update.
REQ-026 Deassertion SHALL allow start_i to be accepted on the first following rising edge.

Structure
REQ-027 The FSM state enum, ACC_W, NUM_AXONS and the saturation limits (+127/-128) SHALL reside in shared package neuron_core_pkg.
REQ-028 The weight mux with sign-extension and the 8-bit saturator SHALL be a combinational sub-module named neuron_weight_sat; all state SHALL live in neuron_integrator.

Verification
REQ-029 vp=10, w1=5, three spike beats type0, last on third, leak=-2, pos_th=20 -> acc=23, spike_o=1, vp_o=pos_reset_i, vp_we_o 3 cycles after the last beat.
REQ-030 vp=0, w2=-50, three spikes type1, leak=0, neg_th=-100, neg_reset=0 -> acc=-150 < -100, vp_o=0, no spike.
REQ-031 vp=100, w3=127, two spikes type2, pos_th=127 (unreachable test by thresholds=127 and acc=354 >= 127 fires); repeat with pos_th=127 and w3=10, one spike, leak=10 -> acc=120, vp_o=120, no spike; with w3=20 -> acc=130, spike_o=1.
REQ-032 256 beats, no axon_last_i, all spikes type3 w4=-128, vp=-128, leak=-128, neg_th=-128 -> counter terminates integration, acc=-33024, no wrap, vp_o=neg_reset_i.
REQ-033 wb_rst_ni pulsed low during INTEG after 5 beats -> no vp_we_o, busy_o=0; next start_i integrates from a fresh voltage_potential_i.
REQ-034 start_i re-pulsed during LEAK and axon_valid_i held high in FIRE -> both ignored, exactly one done_o pulse.

Source files
------------

// File: rtl/neuron_integrator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_core_pkg
// Description : Shared types and constants for the neuron integrator core.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_core_pkg;

    localparam int ACC_W     = 17;
    localparam int NUM_AXONS = 256;

    localparam logic signed [7:0] c_SAT_MAX = 8'sh7F;
    localparam logic signed [7:0] c_SAT_MIN = 8'sh80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTEG = 3'd1,
        ST_LEAK  = 3'd2,
        ST_FIRE  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_integrator_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_integrator_if
// Description : Axon event stream, one event per valid/ready beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_integrator_if;

    logic       axon_valid;
    logic       axon_spike;
    logic [1:0] axon_type;
    logic       axon_last;
    logic       axon_ready;

    modport master (
        output axon_valid, axon_spike, axon_type, axon_last,
        input  axon_ready
    );

    modport slave (
        input  axon_valid, axon_spike, axon_type, axon_last,
        output axon_ready
    );

endinterface
`default_nettype wire

// File: rtl/neuron_integrator_weight_sat.sv
`default_nettype none
// ============================================================================
// Module      : neuron_weight_sat
// Description : Weight select with sign extension and 8-bit saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_weight_sat #(
    parameter int ACC_W = neuron_core_pkg::ACC_W
) (
    input  wire        [1:0]       i_axon_type,
    input  wire signed [7:0]       i_weight1,
    input  wire signed [7:0]       i_weight2,
    input  wire signed [7:0]       i_weight3,
    input  wire signed [7:0]       i_weight4,
    input  wire signed [ACC_W-1:0] i_acc,
    output logic signed [ACC_W-1:0] o_weight,
    output logic signed [7:0]       o_sat
);

    localparam logic signed [ACC_W-1:0] c_MAX_EXT =
        {{(ACC_W-8){1'b0}}, neuron_core_pkg::c_SAT_MAX};
    localparam logic signed [ACC_W-1:0] c_MIN_EXT =
        {{(ACC_W-8){1'b1}}, neuron_core_pkg::c_SAT_MIN};

    logic signed [7:0] w_weight_sel;

    always_comb begin
        w_weight_sel = i_weight1;
        case (i_axon_type)
            2'd0:    w_weight_sel = i_weight1;
            2'd1:    w_weight_sel = i_weight2;
            2'd2:    w_weight_sel = i_weight3;
            default: w_weight_sel = i_weight4;
        endcase
    end

    assign o_weight = {{(ACC_W-8){w_weight_sel[7]}}, w_weight_sel};

    always_comb begin
        o_sat = i_acc[7:0];
        if (i_acc > c_MAX_EXT) begin
            o_sat = neuron_core_pkg::c_SAT_MAX;
        end else if (i_acc < c_MIN_EXT) begin
            o_sat = neuron_core_pkg::c_SAT_MIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_integrator.sv
`default_nettype none
// ============================================================================
// Module      : neuron_integrator
// Description : Integrate axon events, apply leak, threshold and write back.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_integrator #(
    parameter int NUM_AXONS = neuron_core_pkg::NUM_AXONS,
    parameter int ACC_W     = neuron_core_pkg::ACC_W
) (
    input  wire                 wb_clk_i,
    input  wire                 wb_rst_ni,
    input  wire                 start_i,
    neuron_integrator_if.slave  axon,
    input  wire signed [7:0]    voltage_potential_i,
    input  wire signed [7:0]    pos_threshold_i,
    input  wire signed [7:0]    neg_threshold_i,
    input  wire signed [7:0]    leak_value_i,
    input  wire signed [7:0]    weight_type1_i,
    input  wire signed [7:0]    weight_type2_i,
    input  wire signed [7:0]    weight_type3_i,
    input  wire signed [7:0]    weight_type4_i,
    input  wire signed [7:0]    pos_reset_i,
    input  wire signed [7:0]    neg_reset_i,
    output logic signed [7:0]   vp_o,
    output logic                vp_we_o,
    output logic                spike_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int c_CNT_W = $clog2(NUM_AXONS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(NUM_AXONS - 1);

    neuron_core_pkg::state_t r_state;
    neuron_core_pkg::state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0]      r_cnt;
    logic signed [7:0]       r_next_vp;

    logic signed [ACC_W-1:0] w_weight;
    logic signed [7:0]       w_sat;
    logic signed [7:0]       w_fire_vp;
    logic                    w_accept;
    logic                    w_pos_hit;
    logic                    w_neg_hit;

    logic signed [ACC_W-1:0] w_vp_ext;
    logic signed [ACC_W-1:0] w_leak_ext;
    logic signed [ACC_W-1:0] w_pos_th_ext;
    logic signed [ACC_W-1:0] w_neg_th_ext;

    assign w_vp_ext     = {{(ACC_W-8){voltage_potential_i[7]}}, voltage_potential_i};
    assign w_leak_ext   = {{(ACC_W-8){leak_value_i[7]}}, leak_value_i};
    assign w_pos_th_ext = {{(ACC_W-8){pos_threshold_i[7]}}, pos_threshold_i};
    assign w_neg_th_ext = {{(ACC_W-8){neg_threshold_i[7]}}, neg_threshold_i};

    // Accept is decoded from state, not from axon_ready, to keep it loop-free.
    assign w_accept  = axon.axon_valid && (r_state == neuron_core_pkg::ST_INTEG);
    assign w_pos_hit = (r_acc >= w_pos_th_ext);
    assign w_neg_hit = (r_acc <  w_neg_th_ext);

    neuron_weight_sat #(
        .ACC_W (ACC_W)
    ) u_weight_sat (
        .i_axon_type (axon.axon_type),
        .i_weight1   (weight_type1_i),
        .i_weight2   (weight_type2_i),
        .i_weight3   (weight_type3_i),
        .i_weight4   (weight_type4_i),
        .i_acc       (r_acc),
        .o_weight    (w_weight),
        .o_sat       (w_sat)
    );

    always_comb begin
        w_fire_vp = w_sat;
        if (w_pos_hit) begin
            w_fire_vp = pos_reset_i;
        end else if (w_neg_hit) begin
            w_fire_vp = neg_reset_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= neuron_core_pkg::ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        axon.axon_ready = 1'b0;
        busy_o          = 1'b1;
        spike_o         = 1'b0;
        vp_we_o         = 1'b0;
        done_o          = 1'b0;
        vp_o            = '0;
        case (r_state)
            neuron_core_pkg::ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = neuron_core_pkg::ST_INTEG;
                end
            end
            neuron_core_pkg::ST_INTEG: begin
                axon.axon_ready = 1'b1;
                if (w_accept && (axon.axon_last || (r_cnt == c_CNT_END))) begin
                    w_state_nxt = neuron_core_pkg::ST_LEAK;
                end
            end
            neuron_core_pkg::ST_LEAK: begin
                w_state_nxt = neuron_core_pkg::ST_FIRE;
            end
            neuron_core_pkg::ST_FIRE: begin
                spike_o     = w_pos_hit;
                w_state_nxt = neuron_core_pkg::ST_WB;
            end
            neuron_core_pkg::ST_WB: begin
                vp_we_o     = 1'b1;
                done_o      = 1'b1;
                vp_o        = r_next_vp;
                w_state_nxt = neuron_core_pkg::ST_IDLE;
            end
            default: begin
                busy_o      = 1'b0;
                w_state_nxt = neuron_core_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_next_vp <= '0;
        end else begin
            case (r_state)
                neuron_core_pkg::ST_IDLE: begin
                    if (start_i) begin
                        r_acc <= w_vp_ext;
                        r_cnt <= '0;
                    end
                end
                neuron_core_pkg::ST_INTEG: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (axon.axon_spike) begin
                            r_acc <= r_acc + w_weight;
                        end
                    end
                end
                neuron_core_pkg::ST_LEAK: begin
                    r_acc <= r_acc + w_leak_ext;
                end
                neuron_core_pkg::ST_FIRE: begin
                    r_next_vp <= w_fire_vp;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_integrator
// Description : Directed vector bench for neuron_integrator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_integrator;

    typedef struct {
        int vp, w1, w2, w3, w4, typ;
        int nbeats, nzero, use_last;
        int leak, pth, nth, prst, nrst;
        int exp_vp, exp_spike;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic signed [7:0] vp_in, pth, nth, leak, w1, w2, w3, w4, prst, nrst;
    logic signed [7:0] vp_o;
    logic vp_we_o, spike_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    neuron_integrator_if axon_if ();

    neuron_integrator dut (
        .wb_clk_i            (clk),
        .wb_rst_ni           (rst_n),
        .start_i             (start_i),
        .axon                (axon_if.slave),
        .voltage_potential_i (vp_in),
        .pos_threshold_i     (pth),
        .neg_threshold_i     (nth),
        .leak_value_i        (leak),
        .weight_type1_i      (w1),
        .weight_type2_i      (w2),
        .weight_type3_i      (w3),
        .weight_type4_i      (w4),
        .pos_reset_i         (prst),
        .neg_reset_i         (nrst),
        .vp_o                (vp_o),
        .vp_we_o             (vp_we_o),
        .spike_o             (spike_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (vp_we_o) we_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int vp_, w1_, w2_, w3_, w4_, typ_,
                                input int nb_, nz_, ul_, leak_, pth_, nth_,
                                input int pr_, nr_, ev_, es_);
        vec_t v;
        v.vp = vp_; v.w1 = w1_; v.w2 = w2_; v.w3 = w3_; v.w4 = w4_; v.typ = typ_;
        v.nbeats = nb_; v.nzero = nz_; v.use_last = ul_;
        v.leak = leak_; v.pth = pth_; v.nth = nth_; v.prst = pr_; v.nrst = nr_;
        v.exp_vp = ev_; v.exp_spike = es_;
        return v;
    endfunction

    task automatic set_params(input vec_t v);
        vp_in = 8'(v.vp); w1 = 8'(v.w1); w2 = 8'(v.w2); w3 = 8'(v.w3); w4 = 8'(v.w4);
        leak = 8'(v.leak); pth = 8'(v.pth); nth = 8'(v.nth);
        prst = 8'(v.prst); nrst = 8'(v.nrst);
    endtask

    // Called on a falling edge; start is sampled on the next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        bit  seen_spike;
        bit  got_we;
        set_params(v);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, " busy_after_start"}, busy_o, 1);
        for (int i = 0; i < v.nbeats; i++) begin
            axon_if.axon_valid = 1'b1;
            axon_if.axon_spike = (i >= v.nzero);
            axon_if.axon_type  = 2'(v.typ);
            axon_if.axon_last  = (v.use_last != 0) && (i == v.nbeats - 1);
            if (i == 0) check({tag, " ready_in_integ"}, axon_if.axon_ready, 1);
            @(negedge clk);
        end
        axon_if.axon_valid = 1'b0;
        axon_if.axon_last  = 1'b0;
        check({tag, " ready_after_last"}, axon_if.axon_ready, 0);
        lat = 1; seen_spike = 0; got_we = 0;
        for (int k = 0; k < 8; k++) begin
            if (spike_o) seen_spike = 1;
            if (vp_we_o) begin
                got_we = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " we_seen"}, got_we, 1);
        check({tag, " latency"}, lat, 3);
        check({tag, " vp_o"}, vp_o, v.exp_vp);
        check({tag, " done"}, done_o, 1);
        check({tag, " spike"}, seen_spike, v.exp_spike);
        @(negedge clk);
        check({tag, " done_clear"}, done_o, 0);
        check({tag, " idle_busy"}, busy_o, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int we_before;
        int done_seen;
        int vp_seen;

        vecs[0] = mk(10, 5, 2, 3, 4, 0, 3, 0, 1, -2, 20, -100, -5, -7, -5, 1);
        vecs[1] = mk(0, 1, -50, 3, 4, 1, 3, 0, 1, 0, 100, -100, 1, 0, 0, 0);
        vecs[2] = mk(100, 1, 2, 127, 4, 2, 2, 0, 1, 0, 127, -128, 3, -3, 3, 1);
        vecs[3] = mk(100, 1, 2, 10, 4, 2, 1, 0, 1, 10, 127, -128, 3, -3, 120, 0);
        vecs[4] = mk(100, 1, 2, 20, 4, 2, 1, 0, 1, 10, 127, -128, 3, -3, 3, 1);
        vecs[5] = mk(-128, 1, 2, 3, -128, 3, 256, 0, 0, -128, 127, -128, 0, -99, -99, 0);
        vecs[6] = mk(5, 1, 7, 3, 4, 1, 4, 2, 1, -1, 50, -50, 9, -9, 18, 0);
        vecs[7] = mk(15, 1, 2, 3, 5, 3, 1, 0, 1, 0, 20, -50, 11, -11, 11, 1);
        vecs[8] = mk(-40, 1, -10, 3, 4, 1, 1, 0, 1, 0, 50, -50, 11, -11, -50, 0);

        axon_if.axon_valid = 1'b0;
        axon_if.axon_spike = 1'b0;
        axon_if.axon_type  = 2'd0;
        axon_if.axon_last  = 1'b0;
        set_params(vecs[0]);

        repeat (3) @(negedge clk);
        check("rst busy", busy_o, 0);
        check("rst ready", axon_if.axon_ready, 0);
        check("rst vp_we", vp_we_o, 0);
        check("rst done", done_o, 0);
        check("rst spike", spike_o, 0);
        check("rst vp_o", vp_o, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-integration aborts the update without a write strobe.
        set_params(mk(50, 3, 2, 3, 4, 0, 0, 0, 0, 0, 100, -100, 0, 0, 0, 0));
        we_before = we_cnt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            axon_if.axon_valid = 1'b1;
            axon_if.axon_spike = 1'b1;
            axon_if.axon_type  = 2'd0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        axon_if.axon_valid = 1'b0;
        #1;
        check("midrst busy", busy_o, 0);
        check("midrst ready", axon_if.axon_ready, 0);
        check("midrst vp_we", vp_we_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(7, 3, 2, 3, 4, 0, 2, 0, 1, 0, 100, -100, 0, 0, 13, 0), "after_rst");
        check("midrst one_we_total", we_cnt - we_before, 1);

        // start during LEAK and valid during FIRE must both be ignored.
        set_params(mk(1, 2, 2, 3, 4, 0, 0, 0, 0, 0, 100, -100, 0, 0, 0, 0));
        we_before = we_cnt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        axon_if.axon_valid = 1'b1;
        axon_if.axon_spike = 1'b1;
        axon_if.axon_type  = 2'd0;
        axon_if.axon_last  = 1'b0;
        @(negedge clk);
        axon_if.axon_last  = 1'b1;
        @(negedge clk);
        axon_if.axon_valid = 1'b0;
        axon_if.axon_last  = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        axon_if.axon_valid = 1'b1;
        check("ignore ready_in_fire", axon_if.axon_ready, 0);
        done_seen = 0;
        vp_seen   = -1000;
        for (int k = 0; k < 8; k++) begin
            if (done_o) begin
                done_seen++;
                vp_seen = vp_o;
            end
            @(negedge clk);
            axon_if.axon_valid = 1'b0;
        end
        check("ignore done_count", done_seen, 1);
        check("ignore vp_o", vp_seen, 5);
        check("ignore we_count", we_cnt - we_before, 1);
        check("ignore idle_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
